// File: rtl/inst_asm_loader_if.sv
// Bundle between a decoded-instruction source and the instruction memory loader:
// load request, field beats, memory write port, status and a debug view of the loader FSM.
interface inst_asm_loader_if #(parameter int CNT_W = 8);
  // Handshake: a field beat transfers on a rising clk edge where in_valid and in_ready
  // are both 1. The source holds the fields stable while in_valid=1 and in_ready=0;
  // in_ready never depends on in_valid.
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm32;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       state_dbg;

  modport slave (
    input  start, base_addr, count, in_valid,
    input  opcode, funct3, funct7, rd, rs1, rs2, imm32,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, state_dbg
  );

  modport master (
    output start, base_addr, count, in_valid,
    output opcode, funct3, funct7, rd, rs1, rs2, imm32,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, state_dbg
  );
endinterface

// File: rtl/inst_asm_loader.sv
// Encodes RV32I field beats into instruction words and writes them to consecutive words of imem.
// Optional INST_ASM_LOADER_CHECK_EN: unlisted opcodes raise err and are skipped instead of R-encoded.
module inst_asm_loader #(
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    inst_asm_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] rem_q;
    logic             we_q;
    logic [31:0]      waddr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      enc_word;
    logic             illegal;
    logic             beat;

    assign bus.in_ready   = (state_q == LOAD);
    assign beat           = bus.in_valid && (state_q == LOAD);
    assign bus.busy       = (state_q == LOAD) || (state_q == DONE);
    assign bus.done       = (state_q == DONE);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.state_dbg  = state_q;

    // Instruction encoder; the default arm doubles as the fallback for unknown opcodes.
    always_comb begin
        enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        illegal  = 1'b0;
        case (bus.opcode)
            7'b0110011: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            7'b0010011, 7'b0000011, 7'b1100111:
                enc_word = {bus.imm32[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            7'b0100011:
                enc_word = {bus.imm32[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm32[4:0], bus.opcode};
            7'b1100011:
                enc_word = {bus.imm32[12], bus.imm32[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm32[4:1], bus.imm32[11], bus.opcode};
            7'b0110111, 7'b0010111:
                enc_word = {bus.imm32[31:12], bus.rd, bus.opcode};
            7'b1101111:
                enc_word = {bus.imm32[20], bus.imm32[10:1], bus.imm32[11], bus.imm32[19:12],
                            bus.rd, bus.opcode};
            default: begin
                enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
`ifdef INST_ASM_LOADER_CHECK_EN
                illegal  = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = (bus.count == '0) ? DONE : LOAD;
            LOAD: if (beat && rem_q == CNT_W'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= 1'b0;
            if (state_q == IDLE && bus.start) begin
                addr_q <= bus.base_addr;
                rem_q  <= bus.count;
            end
            // Illegal beats still consume a slot in the count but leave no hole in memory.
            if (beat) begin
                rem_q <= rem_q - CNT_W'(1);
                if (!illegal) begin
                    we_q    <= 1'b1;
                    waddr_q <= addr_q;
                    wdata_q <= enc_word;
                    addr_q  <= addr_q + 32'd4;
                end
            end
        end
    end

`ifdef INST_ASM_LOADER_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= beat && illegal;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_asm_loader.sv
// Directed bench for inst_asm_loader: hand-encoded RV32I words checked through an
// expected write queue, plus status/handshake checks around start, stall, wrap and reset.
module tb_inst_asm_loader;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  inst_asm_loader_if #(.CNT_W(CNT_W)) lif ();

  inst_asm_loader #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every imem write must match the head of the expected queue
  always @(negedge clk) begin
    if (lif.imem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        check("imem_addr", lif.imem_addr, exp_addr_q.pop_front());
        check("imem_wdata", lif.imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [31:0] base, input logic [CNT_W-1:0] cnt);
    lif.start     = 1'b1;
    lif.base_addr = base;
    lif.count     = cnt;
    tick();
    lif.start     = 1'b0;
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    lif.opcode = op;  lif.funct3 = f3; lif.funct7 = f7;
    lif.rd     = rd;  lif.rs1    = rs1; lif.rs2   = rs2;
    lif.imm32  = imm;
  endtask

  // Present one beat, wait (bounded) for in_ready, transfer it; exp_we=0 means no write expected.
  task automatic send_beat(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic exp_we,
                           input logic [31:0] exp_addr, input logic [31:0] exp_word);
    int budget;
    budget = 20;
    if (exp_we) begin
      exp_addr_q.push_back(exp_addr);
      exp_data_q.push_back(exp_word);
    end
    set_fields(op, f3, f7, rd, rs1, rs2, imm);
    lif.in_valid = 1'b1;
    while (lif.in_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("beat_timeout", 32'd0, 32'd1);
    tick();
    lif.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    lif.start = 1'b0; lif.base_addr = '0; lif.count = '0; lif.in_valid = 1'b0;
    set_fields(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    tick();
    check("rst_we", {31'd0, lif.imem_we}, 32'd0);
    check("rst_addr", lif.imem_addr, 32'd0);
    check("rst_wdata", lif.imem_wdata, 32'd0);
    check("rst_busy", {31'd0, lif.busy}, 32'd0);
    check("rst_done", {31'd0, lif.done}, 32'd0);
    check("rst_err", {31'd0, lif.err}, 32'd0);
    check("rst_ready", {31'd0, lif.in_ready}, 32'd0);
    check("rst_state", {30'd0, lif.state_dbg}, 32'd0);
    rst = 1'b0;
    tick();

    // single addi x1,x0,5 at 0x100
    do_start(32'h100, 8'd1);
    check("t1_busy", {31'd0, lif.busy}, 32'd1);
    check("t1_ready", {31'd0, lif.in_ready}, 32'd1);
    send_beat(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h100, 32'h00500093);
    check("t1_done", {31'd0, lif.done}, 32'd1);
    check("t1_done_busy", {31'd0, lif.busy}, 32'd1);
    tick();
    check("t1_done_pulse", {31'd0, lif.done}, 32'd0);
    check("t1_idle_busy", {31'd0, lif.busy}, 32'd0);

    // add / sw / jal from address 0
    do_start(32'h0, 8'd3);
    send_beat(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0, 32'h002081B3);
    send_beat(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h4, 32'h0020A423);
    check("t2_not_done", {31'd0, lif.done}, 32'd0);
    send_beat(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h8, 32'h008000EF);
    check("t2_done", {31'd0, lif.done}, 32'd1);
    tick();

    // beq x1,x2,-4 then a 3-cycle stall, next word must land at +4
    do_start(32'h200, 8'd2);
    send_beat(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'h200, 32'hFE208EE3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_we", {31'd0, lif.imem_we}, 32'd0);
      check("t3_stall_ready", {31'd0, lif.in_ready}, 32'd1);
    end
    // lui x5,0x12345
    send_beat(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h204, 32'h123452B7);
    check("t3_done", {31'd0, lif.done}, 32'd1);
    tick();

    // count=0 goes straight to DONE
    do_start(32'h300, 8'd0);
    check("t4_ready", {31'd0, lif.in_ready}, 32'd0);
    check("t4_done", {31'd0, lif.done}, 32'd1);
    tick();
    check("t4_idle", {31'd0, lif.done | lif.busy}, 32'd0);

    // start during LOAD is ignored
    do_start(32'h300, 8'd2);
    send_beat(7'b0000011, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'h10, 1'b1, 32'h300, 32'h01012203);
    do_start(32'h900, 8'd0);
    check("t5_still_load", {31'd0, lif.in_ready}, 32'd1);
    check("t5_no_done", {31'd0, lif.done}, 32'd0);
    send_beat(7'b1100111, 3'd0, 7'd0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1, 32'h304, 32'h00008067);
    check("t5_done", {31'd0, lif.done}, 32'd1);
    tick();

    // address wrap
    do_start(32'hFFFFFFFC, 8'd2);
    send_beat(7'b0010111, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'hABCDE123, 1'b1, 32'hFFFFFFFC, 32'hABCDE317);
    send_beat(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0, 32'h00500093);
    check("t6_done", {31'd0, lif.done}, 32'd1);
    tick();

    // reset after the first of four beats, with a beat presented during reset
    do_start(32'h500, 8'd4);
    send_beat(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h500, 32'h00500093);
    set_fields(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    lif.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lif.in_valid = 1'b0;
    check("t7_we", {31'd0, lif.imem_we}, 32'd0);
    check("t7_busy", {31'd0, lif.busy}, 32'd0);
    check("t7_ready", {31'd0, lif.in_ready}, 32'd0);
    check("t7_wdata", lif.imem_wdata, 32'd0);
    check("t7_state", {30'd0, lif.state_dbg}, 32'd0);
    lif.in_valid = 1'b1;
    tick();
    tick();
    lif.in_valid = 1'b0;
    check("t7_idle_busy", {31'd0, lif.busy}, 32'd0);

    // opcode 0x7F: skipped with err when checking is built in, else R-encoded
    do_start(32'h400, 8'd2);
`ifdef INST_ASM_LOADER_CHECK_EN
    send_beat(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h0);
    check("t8_err", {31'd0, lif.err}, 32'd1);
    check("t8_no_we", {31'd0, lif.imem_we}, 32'd0);
    tick();
    check("t8_err_pulse", {31'd0, lif.err}, 32'd0);
    send_beat(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h400, 32'h00500093);
`else
    send_beat(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 32'h400, 32'h000000FF);
    check("t8_err", {31'd0, lif.err}, 32'd0);
    send_beat(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h404, 32'h00500093);
`endif
    check("t8_done", {31'd0, lif.done}, 32'd1);
    tick();
    tick();

    check("sb_empty", exp_addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
